// File: rtl/prog_loader.sv
// Byte-stream program loader: takes a length byte and data bytes and drives RAM program-mode writes.
// Optional trailing checksum byte and err flag are enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       program_mode,
  output logic [7:0] pm_mar_in,
  output logic       pm_mar_wr,
  output logic [7:0] pm_data,
  output logic       pm_we,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StWaitByte,
    StSetAddr,
    StWrite,
    StCheck,
    StFinish
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] count_q, count_d;
  logic [7:0] addr_q, addr_d;

  logic       in_ready_q, in_ready_d;
  logic       prog_mode_q, prog_mode_d;
  logic [7:0] mar_in_q, mar_in_d;
  logic       mar_wr_q, mar_wr_d;
  logic [7:0] data_q, data_d;
  logic       we_q, we_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       xfer;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       err_q, err_d;
`endif

  // in_ready is a flop, so a transfer is judged on the registered handshake.
  assign xfer = in_valid & in_ready_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLen;
          addr_d  = 8'h00;
          count_d = 9'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d   = 8'h00;
`endif
        end
      end
      StLen: begin
        if (xfer) begin
          // A length byte of zero encodes a full 256-byte image.
          count_d = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
          state_d = StWaitByte;
        end
      end
      StWaitByte: begin
        if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_data;
`endif
          state_d = StSetAddr;
        end
      end
      StSetAddr: state_d = StWrite;
      StWrite: begin
        addr_d  = addr_q + 8'd1;
        count_d = count_q - 9'd1;
        if (count_q == 9'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StFinish;
`endif
        end else begin
          state_d = StWaitByte;
        end
      end
      StCheck: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        if (xfer) state_d = StFinish;
`else
        state_d = StIdle;
`endif
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so that every port comes straight from a flop.
  always_comb begin
    in_ready_d  = (state_d == StLen) || (state_d == StWaitByte) || (state_d == StCheck);
    prog_mode_d = (state_d != StIdle) && (state_d != StFinish);
    mar_wr_d    = (state_d == StSetAddr);
    mar_in_d    = mar_wr_d ? addr_q : mar_in_q;
    we_d        = (state_d == StWrite);
    data_d      = ((state_q == StWaitByte) && xfer) ? in_data : data_q;
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StFinish);
`ifdef PROG_LOADER_CHECKSUM_EN
    err_d       = err_q;
    if ((state_q == StIdle) && start) err_d = 1'b0;
    if ((state_q == StCheck) && xfer) err_d = (in_data != sum_q);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q     <= 9'd0;
      addr_q      <= 8'h00;
      in_ready_q  <= 1'b0;
      prog_mode_q <= 1'b0;
      mar_in_q    <= 8'h00;
      mar_wr_q    <= 1'b0;
      data_q      <= 8'h00;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q       <= 8'h00;
      err_q       <= 1'b0;
`endif
    end else begin
      count_q     <= count_d;
      addr_q      <= addr_d;
      in_ready_q  <= in_ready_d;
      prog_mode_q <= prog_mode_d;
      mar_in_q    <= mar_in_d;
      mar_wr_q    <= mar_wr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      err_q       <= err_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign program_mode = prog_mode_q;
  assign pm_mar_in    = mar_in_q;
  assign pm_mar_wr    = mar_wr_q;
  assign pm_data      = data_q;
  assign pm_we        = we_q;
  assign busy         = busy_q;
  assign done         = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign err          = err_q;
`else
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: cycle-exact vector table plus directed multi-cycle sequences.
// Follows the DUT build: define PROG_LOADER_CHECKSUM_EN for both to exercise the checksum path.
module tb_prog_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       program_mode;
  logic [7:0] pm_mar_in;
  logic       pm_mar_wr;
  logic [7:0] pm_data;
  logic       pm_we;
  logic       busy;
  logic       done;
  logic       err;

  int checks;
  int errors;
  int strobes;
  int wcount;
  logic [7:0] mar_m;
  logic [7:0] mem [256];

  prog_loader u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .program_mode (program_mode),
    .pm_mar_in    (pm_mar_in),
    .pm_mar_wr    (pm_mar_wr),
    .pm_data      (pm_data),
    .pm_we        (pm_we),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {in_ready, pm_mar_wr, pm_mar_in, pm_we, pm_data, program_mode, busy, done, err}
  typedef struct packed {
    logic        st;
    logic        v;
    logic [7:0]  d;
    logic [22:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic st, logic v, logic [7:0] d, logic rdy, logic mw,
                              logic [7:0] ma, logic we, logic [7:0] pd, logic pm, logic bz,
                              logic dn, logic er);
    vec_t r;
    r.st  = st;
    r.v   = v;
    r.d   = d;
    r.exp = {rdy, mw, ma, we, pd, pm, bz, dn, er};
    return r;
  endfunction

  function automatic logic [22:0] obs();
    return {in_ready, pm_mar_wr, pm_mar_in, pm_we, pm_data, program_mode, busy, done, err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RAM model and strobe-exclusivity monitor.
  always @(negedge clk) begin
    if (rst && (pm_mar_wr || pm_we)) begin
      strobes++;
      checks++;
      if ((pm_mar_wr && pm_we) || in_ready) begin
        errors++;
        $display("FAIL strobe_excl: mar_wr=%b we=%b in_ready=%b required one strobe, ready 0",
                 pm_mar_wr, pm_we, in_ready);
      end
      if (pm_mar_wr) mar_m = pm_mar_in;
      if (pm_we) begin
        mem[mar_m] = pm_data;
        wcount++;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL send_timeout: byte %h not accepted, required in_ready within 50", b);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, {31'd0, done}, 32'd1);
    chk({name, "_pm_low"}, {31'd0, program_mode}, 32'd0);
  endtask

  initial begin
    int s0;
    int w0;
    checks   = 0;
    errors   = 0;
    strobes  = 0;
    wcount   = 0;
    mar_m    = 8'h00;
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Session A: single byte, in_valid held high.
    vq.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0));
    vq.push_back(mk(0, 1, 8'h01, 1, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0));
    vq.push_back(mk(0, 1, 8'hDD, 0, 1, 8'h00, 0, 8'hDD, 1, 1, 0, 0));
    vq.push_back(mk(0, 1, 8'hEE, 0, 0, 8'h00, 1, 8'hDD, 1, 1, 0, 0));
`ifdef PROG_LOADER_CHECKSUM_EN
    vq.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 8'hDD, 1, 1, 0, 0));
    vq.push_back(mk(0, 1, 8'hDD, 0, 0, 8'h00, 0, 8'hDD, 0, 1, 1, 0));
`else
    vq.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'hDD, 0, 1, 1, 0));
`endif
    vq.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'hDD, 0, 0, 0, 0));
    // Session B: two bytes, start pulsed while in WRITE must be ignored.
    vq.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 8'hDD, 1, 1, 0, 0));
    vq.push_back(mk(0, 1, 8'h02, 1, 0, 8'h00, 0, 8'hDD, 1, 1, 0, 0));
    vq.push_back(mk(0, 1, 8'hA1, 0, 1, 8'h00, 0, 8'hA1, 1, 1, 0, 0));
    vq.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 8'hA1, 1, 1, 0, 0));
    vq.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 8'hA1, 1, 1, 0, 0));
    vq.push_back(mk(0, 1, 8'hB2, 0, 1, 8'h01, 0, 8'hB2, 1, 1, 0, 0));
    vq.push_back(mk(0, 0, 8'h00, 0, 0, 8'h01, 1, 8'hB2, 1, 1, 0, 0));
`ifdef PROG_LOADER_CHECKSUM_EN
    vq.push_back(mk(0, 0, 8'h00, 1, 0, 8'h01, 0, 8'hB2, 1, 1, 0, 0));
    vq.push_back(mk(0, 1, 8'h53, 0, 0, 8'h01, 0, 8'hB2, 0, 1, 1, 0));
`else
    vq.push_back(mk(0, 0, 8'h00, 0, 0, 8'h01, 0, 8'hB2, 0, 1, 1, 0));
`endif
    vq.push_back(mk(0, 0, 8'h00, 0, 0, 8'h01, 0, 8'hB2, 0, 0, 0, 0));

    #3;
    chk("reset_outputs", {9'd0, obs()}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {9'd0, obs()}, 32'd0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      start    = vq[i].st;
      in_valid = vq[i].v;
      in_data  = vq[i].d;
      @(posedge clk);
      #1;
      if (obs() !== vq[i].exp) begin
        $display("  vector %0d", i);
      end
      chk("table_vec", {9'd0, obs()}, {9'd0, vq[i].exp});
    end
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;

    // Asynchronous reset while in LEN clears every held output at once.
    pulse_start();
    chk("in_len_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("reset_mid_len", {9'd0, obs()}, 32'd0);
    s0 = strobes;
    in_valid = 1'b1;
    in_data  = 8'h05;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    chk("no_strobes_after_reset", strobes, s0);
    chk("idle_after_reset", {31'd0, busy}, 32'd0);

    // Three bytes with 4-cycle input gaps.
    w0 = wcount;
    pulse_start();
    send(8'h03, 4);
    send(8'h11, 4);
    send(8'h22, 4);
    send(8'h33, 4);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h66, 4);
`endif
    wait_done("three");
    chk("three_err", {31'd0, err}, 32'd0);
    chk("three_wcount", wcount - w0, 32'd3);
    chk("three_mem0", {24'd0, mem[0]}, 32'h11);
    chk("three_mem1", {24'd0, mem[1]}, 32'h22);
    chk("three_mem2", {24'd0, mem[2]}, 32'h33);
    @(negedge clk);

    // Length 0x00: 256 bytes, value = index, address wraps through 0xFF.
    w0 = wcount;
    pulse_start();
    send(8'h00, 0);
    for (int i = 0; i < 256; i++) send(8'(i), 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h80, 0);
`endif
    wait_done("full");
    chk("full_wcount", wcount - w0, 32'd256);
    for (int i = 0; i < 256; i++) chk("full_mem", {24'd0, mem[i]}, i);
    @(negedge clk);

`ifdef PROG_LOADER_CHECKSUM_EN
    pulse_start();
    send(8'h02, 0);
    send(8'h10, 0);
    send(8'h20, 0);
    send(8'h30, 0);
    wait_done("csum_ok");
    chk("csum_ok_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    pulse_start();
    send(8'h02, 0);
    send(8'h10, 0);
    send(8'h20, 0);
    send(8'h31, 0);
    wait_done("csum_bad");
    chk("csum_bad_err", {31'd0, err}, 32'd1);
    repeat (3) @(negedge clk);
    chk("csum_err_held", {31'd0, err}, 32'd1);
    pulse_start();
    chk("csum_err_cleared", {31'd0, err}, 32'd0);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    wait_done("csum_after");
    chk("csum_after_err", {31'd0, err}, 32'd0);
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
